// File: rtl/calc_sequencer.sv
// Keypad command sequencer: builds decimal operands A/B, drives the shared ALU handshake
// and selects the display value. Optional ALU watchdog enabled by CALC_TIMEOUT_EN.
module calc_sequencer #(
   parameter int DIGITS  = 8,
   parameter int W       = 27,
   parameter int TIMEOUT = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [3:0]   cmd,
   input  logic         cmd_valid,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   output logic         alu_start,
   input  logic         alu_done,
   input  logic [W:0]   alu_result,
   input  logic         alu_ovf,
   output logic [W-1:0] disp_value,
   output logic         disp_neg,
   output logic         error,
   output logic [2:0]   state
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam longint MAXL = 64'(10) ** DIGITS - 64'd1;
   localparam logic [W:0] MAXV = (W+1)'(MAXL);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_WAIT    = 3'd2,
      S_RESULT  = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, disp_q, disp_d;
   logic [CW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [1:0]     op_q, op_d, pend_q, pend_d;
   logic           chain_q, chain_d, start_q, start_d;
   logic           neg_q, neg_d, err_q, err_d;
   logic [W:0]     res_q, res_d;

`ifdef CALC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]  tmo_q, tmo_d;
`endif

   function automatic logic [W-1:0] append(input logic [W-1:0] acc, input logic [3:0] d);
      logic [W+3:0] t;
      t = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{W{1'b0}}, d};
      return t[W-1:0];
   endfunction

   function automatic logic [W:0] mag(input logic [W:0] v);
      return v[W] ? (~v + 1'b1) : v;
   endfunction

   logic       is_digit, is_op, is_eq, is_bs, clr, in_range;
   logic [1:0] op_code;
   logic [W:0] res_mag, disp_mag;

   always_comb begin
      is_digit = cmd_valid && (cmd <= 4'd9);
      is_op    = cmd_valid && (cmd inside {4'hA, 4'hB, 4'hC});
      is_eq    = cmd_valid && (cmd == 4'hE);
      is_bs    = cmd_valid && (cmd == 4'hF);
      case (cmd)
         4'hA:    op_code = 2'd0;
         4'hB:    op_code = 2'd1;
         default: op_code = 2'd2;
      endcase
      res_mag  = mag(alu_result);
      in_range = !alu_ovf && (res_mag <= MAXV);

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      op_d    = op_q;
      pend_d  = pend_q;
      chain_d = chain_q;
      res_d   = res_q;
      start_d = 1'b0;
      clr     = 1'b0;
`ifdef CALC_TIMEOUT_EN
      tmo_d   = '0;
`endif

      case (state_q)
         S_ENTER_A: begin
            if (is_digit && cnt_a_q != CW'(DIGITS)) begin
               a_d     = append(a_q, cmd);
               cnt_a_d = cnt_a_q + CW'(1);
            end else if (is_bs && cnt_a_q != '0) begin
               a_d     = a_q / W'(10);
               cnt_a_d = cnt_a_q - CW'(1);
            end else if (is_op) begin
               op_d    = op_code;
               b_d     = '0;
               cnt_b_d = '0;
               state_d = S_ENTER_B;
            end
         end
         S_ENTER_B: begin
            if (is_digit && cnt_b_q != CW'(DIGITS)) begin
               b_d     = append(b_q, cmd);
               cnt_b_d = cnt_b_q + CW'(1);
            end else if (is_bs && cnt_b_q != '0) begin
               b_d     = b_q / W'(10);
               cnt_b_d = cnt_b_q - CW'(1);
            end else if (is_op && cnt_b_q == '0) begin
               op_d = op_code;
            end else if (is_op) begin
               pend_d  = op_code;
               chain_d = 1'b1;
               start_d = 1'b1;
               state_d = S_WAIT;
            end else if (is_eq && cnt_b_q != '0) begin
               chain_d = 1'b0;
               start_d = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // The start cycle's own edge never samples alu_done.
            if (alu_done && !start_q) begin
               if (!in_range) begin
                  state_d = S_ERROR;
               end else if (chain_q) begin
                  if (alu_result[W]) begin
                     state_d = S_ERROR;
                  end else begin
                     a_d     = alu_result[W-1:0];
                     cnt_a_d = CW'(DIGITS);
                     op_d    = pend_q;
                     b_d     = '0;
                     cnt_b_d = '0;
                     chain_d = 1'b0;
                     state_d = S_ENTER_B;
                  end
               end else begin
                  res_d   = alu_result;
                  state_d = S_RESULT;
               end
            end
`ifdef CALC_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         S_RESULT: begin
            if (is_digit) begin
               clr     = 1'b1;
            end else if (is_op && !res_q[W]) begin
               a_d     = res_q[W-1:0];
               cnt_a_d = CW'(DIGITS);
               op_d    = op_code;
               b_d     = '0;
               cnt_b_d = '0;
               state_d = S_ENTER_B;
            end else if (is_bs) begin
               clr = 1'b1;
            end
         end
         S_ERROR: begin
            if (is_bs) clr = 1'b1;
         end
         default: clr = 1'b1;
      endcase

      if (clr) begin
         state_d = S_ENTER_A;
         a_d     = is_digit ? {{(W-4){1'b0}}, cmd} : '0;
         cnt_a_d = is_digit ? CW'(1) : '0;
         b_d     = '0;
         cnt_b_d = '0;
         op_d    = '0;
         pend_d  = '0;
         chain_d = 1'b0;
         res_d   = '0;
      end

      // Display is registered from the next-state view so it tracks the accepting edge.
      disp_mag = mag(res_d);
      disp_d   = disp_q;
      neg_d    = 1'b0;
      err_d    = 1'b0;
      case (state_d)
         S_ENTER_A: disp_d = a_d;
         S_ENTER_B: disp_d = (cnt_b_d != '0) ? b_d : a_d;
         S_WAIT:    neg_d  = neg_q;
         S_RESULT: begin
            disp_d = disp_mag[W-1:0];
            neg_d  = res_d[W];
         end
         default: begin
            disp_d = '0;
            err_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_ENTER_A;
         a_q     <= '0;
         b_q     <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         op_q    <= '0;
         pend_q  <= '0;
         chain_q <= 1'b0;
         start_q <= 1'b0;
         res_q   <= '0;
         disp_q  <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         op_q    <= op_d;
         pend_q  <= pend_d;
         chain_q <= chain_d;
         start_q <= start_d;
         res_q   <= res_d;
         disp_q  <= disp_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
      end
   end

`ifdef CALC_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`endif

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign alu_start  = start_q;
   assign disp_value = disp_q;
   assign disp_neg   = neg_q;
   assign error      = err_q;
   assign state      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus randomized command
// streams checked against a decimal-arithmetic calculator model.
module tb_calc_sequencer;
   localparam int DIGITS = 8;
   localparam int W = 27;
   localparam int TIMEOUT = 64;
   localparam longint MAXV = 99999999;
   localparam longint LIM = 64'sd134217728;

   logic clock = 1'b0;
   logic reset;
   logic [3:0] cmd;
   logic cmd_valid, alu_done, alu_ovf;
   logic [W:0] alu_result;
   logic [W-1:0] alu_a, alu_b, disp_value;
   logic [1:0] alu_op;
   logic alu_start, disp_neg, error;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   calc_sequencer #(.DIGITS(DIGITS), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
      .disp_value(disp_value), .disp_neg(disp_neg), .error(error), .state(state)
   );

   // Calculator model: 0 entering A, 1 entering B, 2 waiting, 3 result, 4 error
   int m_state, m_ca, m_cb, m_op, m_pend;
   bit m_chain, e_neg, e_err;
   longint m_a, m_b, m_res, e_disp;

   function automatic void m_show();
      e_err = (m_state == 4);
      case (m_state)
         0: begin e_disp = m_a; e_neg = 0; end
         1: begin e_disp = (m_cb > 0) ? m_b : m_a; e_neg = 0; end
         3: begin e_disp = (m_res < 0) ? -m_res : m_res; e_neg = (m_res < 0); end
         4: begin e_disp = 0; e_neg = 0; end
         default: ;
      endcase
   endfunction

   function automatic void m_clear();
      m_state = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
      m_op = 0; m_pend = 0; m_chain = 0; m_res = 0;
      m_show();
   endfunction

   function automatic void m_cmd(input int c);
      bit dig, opc, eq, bs;
      dig = (c <= 9); opc = (c >= 10 && c <= 12); eq = (c == 14); bs = (c == 15);
      case (m_state)
         0: if (dig && m_ca < DIGITS) begin m_a = m_a * 10 + c; m_ca++; end
            else if (bs && m_ca > 0) begin m_a = m_a / 10; m_ca--; end
            else if (opc) begin m_op = c - 10; m_b = 0; m_cb = 0; m_state = 1; end
         1: if (dig && m_cb < DIGITS) begin m_b = m_b * 10 + c; m_cb++; end
            else if (bs && m_cb > 0) begin m_b = m_b / 10; m_cb--; end
            else if (opc && m_cb == 0) m_op = c - 10;
            else if (opc) begin m_pend = c - 10; m_chain = 1; m_state = 2; end
            else if (eq && m_cb > 0) begin m_chain = 0; m_state = 2; end
         3: if (dig) begin m_clear(); m_a = c; m_ca = 1; end
            else if (opc && m_res >= 0) begin
               m_a = m_res; m_ca = DIGITS; m_op = c - 10; m_b = 0; m_cb = 0; m_state = 1;
            end else if (bs) m_clear();
         4: if (bs) m_clear();
         default: ;
      endcase
      m_show();
   endfunction

   function automatic void m_done(input longint r, input bit ovf);
      longint mg;
      mg = (r < 0) ? -r : r;
      if (ovf || mg > MAXV) m_state = 4;
      else if (m_chain) begin
         if (r < 0) m_state = 4;
         else begin
            m_a = r; m_ca = DIGITS; m_op = m_pend; m_b = 0; m_cb = 0; m_chain = 0; m_state = 1;
         end
      end else begin m_res = r; m_state = 3; end
      m_show();
   endfunction

   function automatic longint alu_model(input longint a, input longint b, input int op);
      case (op)
         0: return a + b;
         1: return a - b;
         default: return a * b;
      endcase
   endfunction

   task automatic send(input int c);
      cmd = 4'(c); cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0; cmd = 4'd0;
      m_cmd(c);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      m_clear();
   endtask

   // Called in the start cycle; answers dly cycles later and reports what the ALU port showed.
   task automatic alu_reply(input longint r, input bit ovf, input int dly,
                            output logic st, output logic [W-1:0] oa, output logic [W-1:0] ob,
                            output logic [1:0] oop, output bit stable);
      st = alu_start; oa = alu_a; ob = alu_b; oop = alu_op; stable = 1;
      for (int i = 0; i < dly; i++) begin
         @(negedge clock);
         if (alu_start !== 1'b0 || alu_a !== oa || alu_b !== ob || alu_op !== oop) stable = 0;
      end
      alu_result = r[W:0]; alu_ovf = ovf; alu_done = 1'b1;
      @(negedge clock);
      alu_done = 1'b0; alu_ovf = 1'b0; alu_result = '0;
      m_done(r, ovf);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if ({alu_a, alu_b, alu_op, alu_start} !== '0) begin
         errors++; $display("FAIL reset_alu got a=%0d b=%0d op=%0d st=%0d exp all 0", alu_a, alu_b, alu_op, alu_start);
      end
      checks++;
      if ({disp_value, disp_neg, error, state} !== '0) begin
         errors++; $display("FAIL reset_disp got disp=%0d neg=%0d err=%0d st=%0d exp all 0", disp_value, disp_neg, error, state);
      end
      reset = 1'b0;
      m_clear();
   endtask

   task automatic test_add();
      logic st; logic [W-1:0] oa, ob; logic [1:0] oop; bit stb;
      do_reset();
      send(3); send(10); send(1); send(14);
      alu_reply(4, 0, 2, st, oa, ob, oop, stb);
      checks++;
      if ({st, oa, ob, oop, stb} !== {1'b1, 27'd3, 27'd1, 2'd0, 1'b1}) begin
         errors++; $display("FAIL add_alu got st=%0d a=%0d b=%0d op=%0d stable=%0d exp 1 3 1 0 1", st, oa, ob, oop, stb);
      end
      checks++;
      if ({state, disp_value, disp_neg} !== {3'd3, 27'd4, 1'b0}) begin
         errors++; $display("FAIL add_result got st=%0d disp=%0d neg=%0d exp 3 4 0", state, disp_value, disp_neg);
      end
      send(7);
      checks++;
      if ({state, disp_value} !== {3'd0, 27'd7}) begin
         errors++; $display("FAIL result_digit got st=%0d disp=%0d exp 0 7", state, disp_value);
      end
   endtask

   task automatic test_sub_neg();
      logic st; logic [W-1:0] oa, ob; logic [1:0] oop; bit stb;
      do_reset();
      send(1); send(11); send(3); send(14);
      alu_reply(-2, 0, 1, st, oa, ob, oop, stb);
      checks++;
      if (oop !== 2'd1) begin errors++; $display("FAIL sub_op got %0d exp 1", oop); end
      checks++;
      if ({disp_value, disp_neg} !== {27'd2, 1'b1}) begin
         errors++; $display("FAIL sub_neg got disp=%0d neg=%0d exp 2 1", disp_value, disp_neg);
      end
      send(10);
      checks++;
      if ({state, disp_value, disp_neg} !== {3'd3, 27'd2, 1'b1}) begin
         errors++; $display("FAIL neg_op_ignored got st=%0d disp=%0d neg=%0d exp 3 2 1", state, disp_value, disp_neg);
      end
   endtask

   task automatic test_digits();
      do_reset();
      send(1); send(2); send(3); send(15); send(4);
      checks++;
      if (disp_value !== 27'd124) begin errors++; $display("FAIL backspace got %0d exp 124", disp_value); end
      do_reset();
      for (int d = 1; d <= 9; d++) send(d);
      checks++;
      if (disp_value !== 27'd12345678) begin errors++; $display("FAIL digit_limit got %0d exp 12345678", disp_value); end
      do_reset();
      send(15);
      checks++;
      if ({state, disp_value} !== '0) begin errors++; $display("FAIL bs_empty got st=%0d disp=%0d exp 0 0", state, disp_value); end
      for (int d = 0; d < 8; d++) send(0);
      send(5);
      checks++;
      if (disp_value !== 27'd0) begin errors++; $display("FAIL leading_zero got %0d exp 0", disp_value); end
   endtask

   task automatic test_chain();
      logic st; logic [W-1:0] oa, ob; logic [1:0] oop; bit stb;
      do_reset();
      send(2); send(10); send(3); send(12);
      alu_reply(5, 0, 1, st, oa, ob, oop, stb);
      checks++;
      if ({state, alu_op, disp_value} !== {3'd1, 2'd2, 27'd5}) begin
         errors++; $display("FAIL chain_state got st=%0d op=%0d disp=%0d exp 1 2 5", state, alu_op, disp_value);
      end
      send(4); send(14);
      alu_reply(20, 0, 3, st, oa, ob, oop, stb);
      checks++;
      if ({st, oa, ob, oop, stb} !== {1'b1, 27'd5, 27'd4, 2'd2, 1'b1}) begin
         errors++; $display("FAIL chain_alu got st=%0d a=%0d b=%0d op=%0d stable=%0d exp 1 5 4 2 1", st, oa, ob, oop, stb);
      end
      checks++;
      if ({state, disp_value} !== {3'd3, 27'd20}) begin
         errors++; $display("FAIL chain_result got st=%0d disp=%0d exp 3 20", state, disp_value);
      end
   endtask

   task automatic test_error();
      logic st; logic [W-1:0] oa, ob; logic [1:0] oop; bit stb;
      do_reset();
      for (int d = 0; d < 8; d++) send(9);
      send(12); send(2); send(14);
      alu_reply(0, 1, 2, st, oa, ob, oop, stb);
      checks++;
      if ({error, disp_value, state} !== {1'b1, 27'd0, 3'd4}) begin
         errors++; $display("FAIL ovf_error got err=%0d disp=%0d st=%0d exp 1 0 4", error, disp_value, state);
      end
      send(5);
      checks++;
      if ({error, state} !== {1'b1, 3'd4}) begin errors++; $display("FAIL error_sticky got err=%0d st=%0d exp 1 4", error, state); end
      send(15);
      checks++;
      if ({error, state, disp_value} !== '0) begin
         errors++; $display("FAIL error_clear got err=%0d st=%0d disp=%0d exp 0 0 0", error, state, disp_value);
      end
      // magnitude one past the display range without the overflow flag
      for (int d = 0; d < 8; d++) send(9);
      send(10); send(1); send(14);
      alu_reply(100000000, 0, 1, st, oa, ob, oop, stb);
      checks++;
      if (error !== 1'b1) begin errors++; $display("FAIL range_error got %0d exp 1", error); end
   endtask

   task automatic test_reset_wait();
      do_reset();
      send(1); send(10); send(1); send(14);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({alu_a, alu_b, alu_op, alu_start, disp_value, disp_neg, error, state} !== '0) begin
         errors++; $display("FAIL reset_wait got st=%0d start=%0d a=%0d disp=%0d exp all 0", state, alu_start, alu_a, disp_value);
      end
      reset = 1'b0;
      alu_result = 28'd9; alu_done = 1'b1;
      @(negedge clock);
      alu_done = 1'b0; alu_result = '0;
      checks++;
      if ({state, disp_value, alu_start, error} !== '0) begin
         errors++; $display("FAIL late_done got st=%0d disp=%0d exp 0 0", state, disp_value);
      end
      m_clear();
   endtask

`ifdef CALC_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      do_reset();
      send(1); send(10); send(2); send(14);
      k = 0;
      while (error !== 1'b1 && k < TIMEOUT + 8) begin @(negedge clock); k++; end
      checks++;
      if (k !== TIMEOUT) begin errors++; $display("FAIL timeout got %0d cycles exp %0d", k, TIMEOUT); end
      alu_result = 28'd3; alu_done = 1'b1;
      @(negedge clock);
      alu_done = 1'b0; alu_result = '0;
      checks++;
      if ({error, state} !== {1'b1, 3'd4}) begin errors++; $display("FAIL timeout_late got err=%0d st=%0d exp 1 4", error, state); end
      do_reset();
   endtask
`endif

   task automatic test_random();
      logic st; logic [W-1:0] oa, ob; logic [1:0] oop; bit stb, ovf;
      longint ea, eb, r; int eo, c, x;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         x = $urandom_range(0, 99);
         if (x < 55) c = $urandom_range(0, 9);
         else if (x < 75) c = $urandom_range(10, 12);
         else if (x < 85) c = 14;
         else if (x < 95) c = 15;
         else c = 13;
         send(c);
         if (m_state == 2) begin
            ea = m_a; eb = m_b; eo = m_op;
            r = alu_model(ea, eb, eo);
            ovf = (r >= LIM) || (r < -LIM);
            alu_reply(r, ovf, $urandom_range(1, 4), st, oa, ob, oop, stb);
            checks++;
            if ({st, oa, ob, oop, stb} !== {1'b1, ea[W-1:0], eb[W-1:0], 2'(eo), 1'b1}) begin
               errors++; $display("FAIL rnd_alu step %0d got st=%0d a=%0d b=%0d op=%0d stable=%0d exp 1 %0d %0d %0d 1",
                                  n, st, oa, ob, oop, stb, ea, eb, eo);
            end
         end
         checks++;
         if ({state, disp_value, disp_neg, error} !== {3'(m_state), e_disp[W-1:0], e_neg, e_err}) begin
            errors++; $display("FAIL rnd_out step %0d cmd %0d got st=%0d disp=%0d neg=%0d err=%0d exp %0d %0d %0d %0d",
                               n, c, state, disp_value, disp_neg, error, m_state, e_disp, e_neg, e_err);
         end
         if ($urandom_range(0, 3) == 0) @(negedge clock);
      end
   endtask

   initial begin
      reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
      alu_done = 1'b0; alu_ovf = 1'b0; alu_result = '0;
      test_reset();
      test_add();
      test_sub_neg();
      test_digits();
      test_chain();
      test_error();
      test_reset_wait();
`ifdef CALC_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-command controller for the calculator datapath.
- Accepts one 4-bit command per strobe and accumulates decimal operands A and B.
- Sequences the shared arithmetic unit through a start/done handshake, then presents the value to be shown on the seven-segment display driver.
- Sits between the command input and the ALU/display path inside the calculator top level.

Parameters:
- DIGITS, 8: maximum decimal digits per operand and per displayed result.
- W, 27: binary operand width; must satisfy 2^W > 10^DIGITS-1.
- TIMEOUT, 64: ALU watchdog limit in cycles; used only with CALC_TIMEOUT_EN.

Ports:
- clock, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- cmd, input, 4: command code. 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1110 equals, 1111 backspace/clear. 1101 is ignored.
- cmd_valid, input, 1: cmd is sampled on every edge where this is high.
- alu_a, output, W: operand A to the ALU.
- alu_b, output, W: operand B to the ALU.
- alu_op, output, 2: 00 add, 01 sub, 10 mul.
- alu_start, output, 1: one-cycle start pulse.
- alu_done, input, 1: ALU result valid (single-cycle pulse).
- alu_result, input, W+1: signed two's-complement ALU result.
- alu_ovf, input, 1: ALU overflow flag, qualified by alu_done.
- disp_value, output, W: magnitude to display.
- disp_neg, output, 1: minus sign for the display.
- error, output, 1: error indicator.
- state, output, 3: current state for debug.

Behaviour:
- Reset: every output is 0. state=ENTER_A; A=B=0; digit counters=0; chain flag=0.
- States: ENTER_A=0, ENTER_B=1, WAIT_ALU=2, RESULT=3, ERROR=4.
- Digit in ENTER_A or ENTER_B:
  - acc <= acc*10+d and count++ when count<DIGITS.
  - Ignored when count==DIGITS.
  - Leading zeros count as digits.
- Backspace in ENTER_A/ENTER_B: acc <= acc/10 and count-- when count>0; otherwise ignored.
- Operator:
  - ENTER_A: latch op, go to ENTER_B with B=0.
  - ENTER_B with countB==0: replaces the latched op.
  - ENTER_B with countB>0: chain. Store the new op as pending, set the chain flag, go to WAIT_ALU.
- Equals:
  - ENTER_B with countB>0: go to WAIT_ALU with the chain flag cleared.
  - ENTER_A, or ENTER_B with countB==0: ignored.
- WAIT_ALU:
  - alu_start=1 in exactly the first cycle after the accepting edge.
  - alu_a, alu_b and alu_op stay stable from start until the edge where alu_done is seen.
  - cmd_valid is ignored.
  - alu_done is sampled only in WAIT_ALU, never in the start cycle's own edge.
- On alu_done:
  - If alu_ovf=1 or |alu_result|>10^DIGITS-1, go to ERROR.
  - Else, if the chain flag is set: A <= result, op <= pending, B=0, countA=DIGITS, go to ENTER_B. Chaining on a negative result goes to ERROR.
  - Else go to RESULT and latch the result.
- RESULT:
  - A digit clears everything, enters that digit as A's first digit, and goes to ENTER_A.
  - An operator with a non-negative result sets A=result, latches op, and goes to ENTER_B.
  - An operator with a negative result is ignored.
  - Backspace clears to the reset state.
  - Equals is ignored.
- ERROR: error=1, disp_value=0. Only backspace (1111) or reset leaves it, returning to the reset state.
- Display:
  - ENTER_A shows A.
  - ENTER_B shows B if countB>0, else A.
  - WAIT_ALU holds the previous value.
  - RESULT shows |result| with disp_neg=sign.
  - disp_neg=0 in every other state.
- Latency: a command accepted at edge N is reflected in outputs after edge N. alu_done at edge M is reflected after edge M.
- Reset asserted in any state, including WAIT_ALU, overrides everything. Any later alu_done is ignored.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ALU. If TIMEOUT cycles pass without alu_done, go to ERROR; a late alu_done is then ignored.
- Undefined: no counter; the block waits in WAIT_ALU indefinitely.

Test Plan:
- 3, 1010, 1, 1110; ALU answers 4 two cycles after start -> single alu_start with a=3, b=1, op=00; then state=RESULT, disp_value=4, disp_neg=0.
- 1, 1011, 3, 1110; ALU returns -2 -> disp_value=2, disp_neg=1; then 1010 is ignored and state stays RESULT.
- 1, 2, 3, 1111, 4 -> disp_value=124. Keying 1..9 (nine digits) -> disp_value=12345678.
- 2, 1010, 3, 1100; ALU returns 5 -> ENTER_B with op=10. Then 4, 1110; ALU returns 20 -> alu_a=5, alu_b=4, disp_value=20.
- 99999999, 1100, 2, 1110; ALU returns ovf=1 -> error=1, disp_value=0; cmd 5 is ignored; 1111 -> error=0, state=ENTER_A.
- reset during WAIT_ALU -> all outputs 0 next cycle; late alu_done has no effect. With CALC_TIMEOUT_EN and no alu_done -> error=1 exactly TIMEOUT cycles after start.
